// File: rtl/conv_win_sched_if.sv
// Handshake and bus bundle between conv_win_sched and its host/datapath.
// The master modport is the scheduler side; the slave modport is the
// host/SRAM/datapath side.
interface conv_win_sched_if #(
  parameter int RW = 4,
  parameter int CW = 4,
  parameter int OW = 8
);
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          img_load;
  logic          img_clr;
  logic          trig;
  logic          calc_done;
  logic          out_ready;
  logic          out_we;
  logic [OW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic [31:0]   perf_cyc;

  modport master (
    input  start, abort, calc_done, out_ready,
    output rd_en, rd_row, rd_col, img_load, img_clr, trig,
           out_we, out_idx, busy, done, perf_cyc
  );

  modport slave (
    output start, abort, calc_done, out_ready,
    input  rd_en, rd_row, rd_col, img_load, img_clr, trig,
           out_we, out_idx, busy, done, perf_cyc
  );
endinterface

// File: rtl/conv_win_sched.sv
// conv_win_sched: autonomous window sequencer for the 3-row conv datapath.
// Walks a K_H x K_W window over an IN_H x IN_W image: clears the circular
// register at each output row, fetches K_W columns, then one column per
// further window, triggers the datapath, waits for completion and writes
// linear output indices.
// Optional feature macro: SCHED_PERF_EN enables the 32-bit saturating
// busy-cycle counter on perf_cyc; otherwise perf_cyc is tied to zero.
module conv_win_sched #(
  parameter int IN_H = 16,
  parameter int IN_W = 15,
  parameter int K_H  = 3,
  parameter int K_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  conv_win_sched_if.master   bus
);

  localparam int RW = $clog2(IN_H);
  localparam int CW = $clog2(IN_W);
  localparam int OW = $clog2((IN_H - K_H + 1) * (IN_W - K_W + 1));

  localparam logic [CW-1:0] KW_LAST  = CW'(K_W - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - K_H);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RD   = 3'd2,
    S_LD   = 3'd3,
    S_TRIG = 3'd4,
    S_WAIT = 3'd5,
    S_WR   = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [RW-1:0] row_r;
  logic [RW-1:0] row_nxt_s;
  logic [CW-1:0] col_r;
  logic [CW-1:0] col_nxt_s;
  logic [OW-1:0] out_cnt_r;
  logic [OW-1:0] out_cnt_nxt_s;

  // State and position counters; everything returns to IDLE/zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      row_r     <= {RW{1'b0}};
      col_r     <= {CW{1'b0}};
      out_cnt_r <= {OW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      row_r     <= row_nxt_s;
      col_r     <= col_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
    end
  end

  // Next-state and counter update; abort overrides every other transition.
  always_comb begin
    state_nxt_s   = state_r;
    row_nxt_s     = row_r;
    col_nxt_s     = col_r;
    out_cnt_nxt_s = out_cnt_r;
    if (bus.abort) begin
      state_nxt_s   = S_IDLE;
      row_nxt_s     = {RW{1'b0}};
      col_nxt_s     = {CW{1'b0}};
      out_cnt_nxt_s = {OW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            state_nxt_s = S_CLR;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_CLR: begin
          col_nxt_s   = {CW{1'b0}};
          state_nxt_s = S_RD;
        end
        S_RD: begin
          state_nxt_s = S_LD;
        end
        S_LD: begin
          // Keep fetching until K_W columns of the window are resident.
          if (col_r < KW_LAST) begin
            col_nxt_s   = col_r + CW'(1);
            state_nxt_s = S_RD;
          end else begin
            state_nxt_s = S_TRIG;
          end
        end
        S_TRIG: begin
          state_nxt_s = S_WAIT;
        end
        S_WAIT: begin
          if (bus.calc_done) begin
            state_nxt_s = S_WR;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_WR: begin
          if (bus.out_ready) begin
            out_cnt_nxt_s = out_cnt_r + OW'(1);
            if (col_r < COL_LAST) begin
              // Slide right: only the new rightmost column is fetched.
              col_nxt_s   = col_r + CW'(1);
              state_nxt_s = S_RD;
            end else if (row_r < ROW_LAST) begin
              row_nxt_s   = row_r + RW'(1);
              state_nxt_s = S_CLR;
            end else begin
              state_nxt_s = S_FIN;
            end
          end else begin
            state_nxt_s = S_WR;
          end
        end
        S_FIN: begin
          row_nxt_s     = {RW{1'b0}};
          col_nxt_s     = {CW{1'b0}};
          out_cnt_nxt_s = {OW{1'b0}};
          state_nxt_s   = S_IDLE;
        end
        default: begin
          row_nxt_s     = {RW{1'b0}};
          col_nxt_s     = {CW{1'b0}};
          out_cnt_nxt_s = {OW{1'b0}};
          state_nxt_s   = S_IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from the state register; only out_we also depends on the
  // sink handshake, and it is suppressed in an aborting cycle.
  always_comb begin
    bus.rd_en    = 1'b0;
    bus.img_load = 1'b0;
    bus.img_clr  = 1'b0;
    bus.trig     = 1'b0;
    bus.out_we   = 1'b0;
    bus.done     = 1'b0;
    case (state_r)
      S_CLR:   bus.img_clr  = 1'b1;
      S_RD:    bus.rd_en    = 1'b1;
      S_LD:    bus.img_load = 1'b1;
      S_TRIG:  bus.trig     = 1'b1;
      S_WR:    bus.out_we   = bus.out_ready & ~bus.abort;
      S_FIN:   bus.done     = 1'b1;
      default: bus.done     = 1'b0;
    endcase
  end

  assign bus.busy    = (state_r != S_IDLE);
  assign bus.rd_row  = row_r;
  assign bus.rd_col  = col_r;
  assign bus.out_idx = out_cnt_r;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_r;

  // Busy-cycle counter: cleared on an accepted start, saturates, holds in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= 32'd0;
    end else if ((state_r == S_IDLE) && bus.start && !bus.abort) begin
      perf_r <= 32'd0;
    end else if ((state_r != S_IDLE) && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perf_cyc = perf_r;
`else
  assign bus.perf_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// Scoreboard bench for conv_win_sched at default parameters (16x15 image,
// 3x3 kernel): expected read addresses and output indices are queued when a
// pass is launched and a negedge monitor pops and compares them.
module tb_conv_win_sched;
  localparam int IN_H = 16;
  localparam int IN_W = 15;
  localparam int K_H  = 3;
  localparam int K_W  = 3;
  localparam int RW   = $clog2(IN_H);
  localparam int CW   = $clog2(IN_W);
  localparam int OW   = $clog2((IN_H - K_H + 1) * (IN_W - K_W + 1));
  localparam int N_ROWS = IN_H - K_H + 1;   // 14
  localparam int N_COLS = IN_W - K_W + 1;   // 13
  localparam int N_OUT  = N_ROWS * N_COLS;  // 182
  localparam int N_RD   = N_ROWS * IN_W;    // 210
  // 14 rows x (CLR + 3 RD/LD + TRIG,WAIT,WR + 12 x 5) + FIN
  localparam int PASS_BUSY = N_ROWS * (1 + 2 * K_W + 3 + (N_COLS - 1) * 5) + 1;

  logic clk;
  logic rst;

  conv_win_sched_if #(.RW(RW), .CW(CW), .OW(OW)) bus ();

  conv_win_sched #(.IN_H(IN_H), .IN_W(IN_W), .K_H(K_H), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, clr_cnt = 0, trig_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic spur_en = 1'b0;

  logic [RW+CW-1:0] rd_q[$];
  int               wr_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; clr_cnt = 0; trig_cnt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic push_pass();
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < IN_W; c++) begin
        rd_q.push_back({r[RW-1:0], c[CW-1:0]});
      end
    end
    for (int i = 0; i < N_OUT; i++) wr_q.push_back(i);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (wr_cnt < target) begin
      errors++;
      $display("FAIL wr_timeout: wr_cnt %0d expected %0d", wr_cnt, target);
    end
  endtask

  // Datapath model: calc_done one cycle after trig; optional spurious pulses in RD/LD.
  initial begin
    bus.calc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.trig) begin
        @(posedge clk); #1 bus.calc_done = 1'b1;
        @(posedge clk); #1 bus.calc_done = 1'b0;
      end else if (spur_en && (bus.rd_en || bus.img_load)) begin
        bus.calc_done = 1'b1;
        @(posedge clk); #1 bus.calc_done = 1'b0;
      end
    end
  end

  // Monitor: pops expected reads/writes, counts events, checks strobe exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra: unexpected read row %0d col %0d", bus.rd_row, bus.rd_col);
        end else begin
          chk("rd_addr", {bus.rd_row, bus.rd_col}, rd_q.pop_front());
        end
      end
      if (bus.out_we) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_extra: unexpected write idx %0d", bus.out_idx);
        end else begin
          chk("out_idx", bus.out_idx, wr_q.pop_front());
        end
      end
      if (bus.img_clr) clr_cnt++;
      if (bus.trig) trig_cnt++;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.rd_en | bus.img_load | bus.img_clr | bus.trig | bus.out_we) begin
        chk("strobe_onehot",
            $countones({bus.rd_en, bus.img_load, bus.img_clr, bus.trig, bus.out_we}), 1);
      end
    end
  end

  task automatic check_pass_totals(input string tag, input bit check_busy);
    chk({tag, "_writes"}, wr_cnt, N_OUT);
    chk({tag, "_reads"}, rd_cnt, N_RD);
    chk({tag, "_clrs"}, clr_cnt, N_ROWS);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_queues"}, rd_q.size() + wr_q.size(), 0);
    if (check_busy) chk({tag, "_busy_cycles"}, busy_cnt, PASS_BUSY);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.rd_en, bus.img_load, bus.img_clr, bus.trig, bus.out_we, bus.done}, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_perf", bus.perf_cyc, 0);

    // start and abort together in IDLE: stay IDLE
    @(posedge clk); #1 bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", bus.busy, 0);

    // T2: full pass with immediate handshakes
    clear_counts();
    push_pass();
    pulse_start();
    wait_done(3000);
    check_pass_totals("t2", 1'b1);
`ifdef SCHED_PERF_EN
    chk("t2_perf", bus.perf_cyc, PASS_BUSY);
`else
    chk("t2_perf", bus.perf_cyc, 0);
`endif

    // T3: sink stalls around window 5
    clear_counts();
    push_pass();
    pulse_start();
    wait_wr(5, 500);
    #1 bus.out_ready = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("t3_stall_writes", wr_cnt, 5);
    chk("t3_stall_reads", rd_cnt, 8);
    chk("t3_stall_busy", bus.busy, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(3000);
    check_pass_totals("t3", 1'b0);

    // T4: abort while waiting on window 7
    clear_counts();
    push_pass();
    pulse_start();
    begin
      int n;
      n = 0;
      while (trig_cnt < 8 && n < 500) begin
        @(posedge clk);
        n++;
      end
    end
    chk("t4_trig_reached", trig_cnt, 8);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_busy_after_abort", bus.busy, 0);
    chk("t4_out_idx_cleared", bus.out_idx, 0);
    repeat (40) @(posedge clk);
    chk("t4_writes", wr_cnt, 7);
    chk("t4_no_done", done_cnt, 0);
    rd_q.delete();
    wr_q.delete();
    clear_counts();
    push_pass();
    pulse_start();
    wait_done(3000);
    check_pass_totals("t4_restart", 1'b1);

    // T6: asynchronous reset in the middle of a read
    clear_counts();
    push_pass();
    pulse_start();
    wait_wr(3, 500);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.rd_en && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_in_rd", bus.rd_en, 1);
    rst = 1'b1;
    #1;
    chk("t6_strobes", {bus.rd_en, bus.img_load, bus.img_clr, bus.trig, bus.out_we, bus.done}, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_addr", {bus.rd_row, bus.rd_col, bus.out_idx}, 0);
    chk("t6_perf", bus.perf_cyc, 0);
    @(posedge clk); #1 rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_idle_after", bus.busy, 0);

    // T5: spurious calc_done in RD/LD and a start mid-pass
    clear_counts();
    push_pass();
    spur_en = 1'b1;
    pulse_start();
    wait_wr(2, 500);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(3000);
    spur_en = 1'b0;
    check_pass_totals("t5", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
